// File: rtl/xoodyak_loader_pkg.sv
// Shared types and field geometry for the Xoodyak word-serial loader.
// Holds the loader FSM state enum, per-field word counts and field widths.
package xoodyak_pkg;

  localparam int LDR_WORD_W  = 32;
  localparam int LDR_CNT_W   = 3;

  localparam int KEY_WORDS   = 4;
  localparam int NONCE_WORDS = 4;
  localparam int AD_WORDS    = 4;
  localparam int TEXT_WORDS  = 6;
  localparam int TAG_WORDS   = 4;

  localparam int KEY_W   = KEY_WORDS   * LDR_WORD_W;
  localparam int NONCE_W = NONCE_WORDS * LDR_WORD_W;
  localparam int AD_W    = AD_WORDS    * LDR_WORD_W;
  localparam int TEXT_W  = TEXT_WORDS  * LDR_WORD_W;
  localparam int TAG_W   = TAG_WORDS   * LDR_WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_NONCE,
    ST_LOAD_AD,
    ST_LOAD_TEXT,
    ST_LOAD_TAG,
    ST_FIRE,
    ST_BUSY
  } loader_state_t;

  // Index of the final word of the field loaded in state s.
  function automatic logic [LDR_CNT_W-1:0] field_last(input loader_state_t s);
    logic [LDR_CNT_W-1:0] last;
    last = '0;
    case (s)
      ST_LOAD_KEY:   last = LDR_CNT_W'(KEY_WORDS - 1);
      ST_LOAD_NONCE: last = LDR_CNT_W'(NONCE_WORDS - 1);
      ST_LOAD_AD:    last = LDR_CNT_W'(AD_WORDS - 1);
      ST_LOAD_TEXT:  last = LDR_CNT_W'(TEXT_WORDS - 1);
      ST_LOAD_TAG:   last = LDR_CNT_W'(TAG_WORDS - 1);
      default:       last = '0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/xoodyak_loader_if.sv
// Command and stream handshakes between a word producer and xoodyak_loader.
// The master drives commands and words; the slave (the loader) drives the readies.
interface xoodyak_loader_if;
  import xoodyak_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_opmode;
  logic                  cmd_keep_key;
  logic                  in_valid;
  logic                  in_ready;
  logic [LDR_WORD_W-1:0] in_data;

  modport master (
    output cmd_valid, cmd_opmode, cmd_keep_key, in_valid, in_data,
    input  cmd_ready, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_opmode, cmd_keep_key, in_valid, in_data,
    output cmd_ready, in_ready
  );

endinterface

// File: rtl/xoodyak_field_reg.sv
// Word-addressed wide register: word idx is written with wdata when we is high.
// Word 0 occupies the least significant WORD_W bits; unaddressed words hold.
module xoodyak_field_reg #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int IDX_W  = 3
) (
  input  logic                    eph1,
  input  logic                    reset,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [WORD_W-1:0]       wdata,
  output logic [WORDS*WORD_W-1:0] q
);

  // NOTE: these operand registers are reset explicitly because the core
  // must see all-zero operands after reset; they are not RAM-like storage.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (we && idx == IDX_W'(k)) begin
          q[k*WORD_W +: WORD_W] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/xoodyak_loader.sv
// Word-serial front end for xoodyak_build: assembles operands, pulses start, waits for done.
// Define XOODYAK_LOADER_KEYHOLD_EN to honour cmd_keep_key (skip key load, reuse held key).
module xoodyak_loader
  import xoodyak_pkg::*;
#(
  parameter int WORD_W = LDR_WORD_W
) (
  input  logic               eph1,
  input  logic               reset,
  xoodyak_loader_if.slave    bus,
  input  logic               core_done,
  output logic [KEY_W-1:0]   key,
  output logic [NONCE_W-1:0] nonce,
  output logic [AD_W-1:0]    assodata,
  output logic [TEXT_W-1:0]  textin,
  output logic [TAG_W-1:0]   verification_data,
  output logic               opmode,
  output logic               start,
  output logic               busy
);

  loader_state_t          state, state_nxt;
  logic [LDR_CNT_W-1:0]   cnt, cnt_nxt;
  logic                   opmode_q;
  logic                   load_st;
  logic                   cmd_accept;
  logic                   word_fire;
  logic                   last_word;
  logic                   keep_key_eff;

  assign load_st = (state == ST_LOAD_KEY)  || (state == ST_LOAD_NONCE) ||
                   (state == ST_LOAD_AD)   || (state == ST_LOAD_TEXT)  ||
                   (state == ST_LOAD_TAG);

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.in_ready  = load_st;
  assign start         = (state == ST_FIRE);
  assign busy          = (state != ST_IDLE);
  assign opmode        = opmode_q;

  assign cmd_accept = bus.cmd_valid && (state == ST_IDLE);
  assign word_fire  = bus.in_valid && load_st;
  assign last_word  = word_fire && (cnt == field_last(state));

`ifdef XOODYAK_LOADER_KEYHOLD_EN
  assign keep_key_eff = bus.cmd_keep_key;
`else
  assign keep_key_eff = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (cmd_accept) state_nxt = keep_key_eff ? ST_LOAD_NONCE : ST_LOAD_KEY;
      ST_LOAD_KEY:   if (last_word)  state_nxt = ST_LOAD_NONCE;
      ST_LOAD_NONCE: if (last_word)  state_nxt = ST_LOAD_AD;
      ST_LOAD_AD:    if (last_word)  state_nxt = ST_LOAD_TEXT;
      ST_LOAD_TEXT:  if (last_word)  state_nxt = opmode_q ? ST_LOAD_TAG : ST_FIRE;
      ST_LOAD_TAG:   if (last_word)  state_nxt = ST_FIRE;
      // The core cannot finish in zero cycles, so done is not looked at in FIRE.
      ST_FIRE:                       state_nxt = ST_BUSY;
      ST_BUSY:       if (core_done)  state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase

    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (word_fire) begin
      cnt_nxt = cnt + LDR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      opmode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cmd_accept) begin
        opmode_q <= bus.cmd_opmode;
      end
    end
  end

  xoodyak_field_reg #(.WORD_W(WORD_W), .WORDS(KEY_WORDS), .IDX_W(LDR_CNT_W)) u_key (
    .eph1  (eph1),
    .reset (reset),
    .we    (word_fire && state == ST_LOAD_KEY),
    .idx   (cnt),
    .wdata (bus.in_data),
    .q     (key)
  );

  xoodyak_field_reg #(.WORD_W(WORD_W), .WORDS(NONCE_WORDS), .IDX_W(LDR_CNT_W)) u_nonce (
    .eph1  (eph1),
    .reset (reset),
    .we    (word_fire && state == ST_LOAD_NONCE),
    .idx   (cnt),
    .wdata (bus.in_data),
    .q     (nonce)
  );

  xoodyak_field_reg #(.WORD_W(WORD_W), .WORDS(AD_WORDS), .IDX_W(LDR_CNT_W)) u_ad (
    .eph1  (eph1),
    .reset (reset),
    .we    (word_fire && state == ST_LOAD_AD),
    .idx   (cnt),
    .wdata (bus.in_data),
    .q     (assodata)
  );

  xoodyak_field_reg #(.WORD_W(WORD_W), .WORDS(TEXT_WORDS), .IDX_W(LDR_CNT_W)) u_text (
    .eph1  (eph1),
    .reset (reset),
    .we    (word_fire && state == ST_LOAD_TEXT),
    .idx   (cnt),
    .wdata (bus.in_data),
    .q     (textin)
  );

  xoodyak_field_reg #(.WORD_W(WORD_W), .WORDS(TAG_WORDS), .IDX_W(LDR_CNT_W)) u_tag (
    .eph1  (eph1),
    .reset (reset),
    .we    (word_fire && state == ST_LOAD_TAG),
    .idx   (cnt),
    .wdata (bus.in_data),
    .q     (verification_data)
  );

endmodule

// File: tb/tb_xoodyak_loader.sv
// Self-checking bench for xoodyak_loader: directed frames with random data and gaps,
// checked against a field-level model of the operand registers and frame timing.
module tb_xoodyak_loader;

  logic         eph1 = 1'b0;
  logic         reset;
  logic         core_done;
  logic [127:0] key, nonce, assodata, verification_data;
  logic [191:0] textin;
  logic         opmode, start, busy;

  xoodyak_loader_if bus_if ();

  xoodyak_loader dut (
    .eph1              (eph1),
    .reset             (reset),
    .bus               (bus_if),
    .core_done         (core_done),
    .key               (key),
    .nonce             (nonce),
    .assodata          (assodata),
    .textin            (textin),
    .verification_data (verification_data),
    .opmode            (opmode),
    .start             (start),
    .busy              (busy)
  );

  always #5 eph1 = ~eph1;

`ifdef XOODYAK_LOADER_KEYHOLD_EN
  localparam bit KK_HONOURED = 1'b1;
`else
  localparam bit KK_HONOURED = 1'b0;
`endif

  localparam logic [127:0] S1_KEY = 128'h38393a3b3c3d3e3f3031323334353637;
  localparam logic [127:0] TAG_V  = 128'h0123456789abcdef0123456789abcdef;

  int total = 0;
  int bad   = 0;

  logic [31:0]  stim_q[$];
  logic [31:0]  s1_words[$];
  logic [127:0] m_key, m_nonce, m_ad, m_tag;
  logic [191:0] m_text;
  logic         m_op;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_nonce = '0; m_ad = '0; m_text = '0; m_tag = '0; m_op = 1'b0;
  endtask

  // Walks the field list a frame visits and drops stream words into place.
  task automatic model_frame(input bit op, input bit kk, output int need);
    int fld[$];
    int nw[5] = '{4, 4, 4, 6, 4};
    int pos = 0;
    if (!(kk && KK_HONOURED)) fld.push_back(0);
    fld.push_back(1); fld.push_back(2); fld.push_back(3);
    if (op) fld.push_back(4);
    m_op = op;
    need = 0;
    foreach (fld[i]) begin
      for (int k = 0; k < nw[fld[i]]; k++) begin
        if (pos < stim_q.size()) begin
          case (fld[i])
            0: m_key[32*k +: 32]   = stim_q[pos];
            1: m_nonce[32*k +: 32] = stim_q[pos];
            2: m_ad[32*k +: 32]    = stim_q[pos];
            3: m_text[32*k +: 32]  = stim_q[pos];
            default: m_tag[32*k +: 32] = stim_q[pos];
          endcase
        end
        pos++;
      end
      need += nw[fld[i]];
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".key"},    key,               m_key);
    check({tag, ".nonce"},  nonce,             m_nonce);
    check({tag, ".ad"},     assodata,          m_ad);
    check({tag, ".text"},   textin,            m_text);
    check({tag, ".tag"},    verification_data, m_tag);
    check({tag, ".opmode"}, opmode,            m_op);
  endtask

  task automatic do_reset(input string tag);
    @(posedge eph1); #3;
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.in_valid  = 1'b0;
    core_done        = 1'b0;
    model_reset();
    @(negedge eph1);
    check_outputs({tag, ".in_rst"});
    check({tag, ".rst_start"},    start,           1'b0);
    check({tag, ".rst_busy"},     busy,            1'b0);
    check({tag, ".rst_in_ready"}, bus_if.in_ready, 1'b0);
    @(posedge eph1); #3;
    reset = 1'b0;
    @(negedge eph1);
    check({tag, ".cmd_ready"}, bus_if.cmd_ready, 1'b1);
    check({tag, ".busy"},      busy,             1'b0);
    check({tag, ".in_ready"},  bus_if.in_ready,  1'b0);
  endtask

  // Issues a command, streams stim_q honouring in_ready with random gaps,
  // and checks start timing plus the BUSY/done behaviour when a start is expected.
  task automatic run_frame(input string tag, input bit op, input bit kk, input int gap_pct,
                           input bit hold_busy, input bit done_in_fire, input bit expect_start);
    int cyc, idx, gaps, nstart, start_cyc, extra, tail;
    @(negedge eph1);
    check({tag, ".cmd_ready"}, bus_if.cmd_ready, 1'b1);
    bus_if.cmd_valid    = 1'b1;
    bus_if.cmd_opmode   = op;
    bus_if.cmd_keep_key = kk;
    @(posedge eph1); #1;
    bus_if.cmd_valid    = 1'b0;
    bus_if.cmd_opmode   = 1'($urandom);
    bus_if.cmd_keep_key = 1'($urandom);
    cyc = 1; idx = 0; gaps = 0; nstart = 0; start_cyc = 0; extra = 0; tail = 0;
    while (nstart == 0 && cyc < 300) begin
      if (idx < stim_q.size() && int'($urandom_range(99)) >= gap_pct) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = stim_q[idx];
      end else begin
        bus_if.in_valid = (idx >= stim_q.size()) ? hold_busy : 1'b0;
        bus_if.in_data  = $urandom;
        if (idx < stim_q.size()) gaps++;
      end
      @(negedge eph1);
      if (start) begin
        nstart++;
        start_cyc = cyc;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        if (idx < stim_q.size()) idx++;
        else extra++;
      end
      if (start && done_in_fire) core_done = 1'b1;
      if (idx >= stim_q.size()) tail++;
      @(posedge eph1); #1;
      core_done = 1'b0;
      cyc++;
      if (!expect_start && tail > 4) break;
    end
    check({tag, ".start_count"}, nstart, expect_start ? 1 : 0);
    check({tag, ".words_used"},  idx,    stim_q.size());
    check({tag, ".extra_words"}, extra,  0);
    if (expect_start) begin
      check({tag, ".start_cycle"}, start_cyc, 1 + stim_q.size() + gaps);
      for (int b = 0; b < 3; b++) begin
        @(negedge eph1);
        check({tag, ".busy_hold"},     busy,            1'b1);
        check({tag, ".busy_in_ready"}, bus_if.in_ready, 1'b0);
        check({tag, ".busy_no_start"}, start,           1'b0);
        if (bus_if.in_valid && bus_if.in_ready) extra++;
        @(posedge eph1); #1;
      end
      check({tag, ".busy_consumed"}, extra, 0);
      core_done = 1'b1;
      @(negedge eph1);
      check({tag, ".busy_before_done"}, busy, 1'b1);
      @(posedge eph1); #1;
      core_done       = 1'b0;
      bus_if.in_valid = 1'b0;
      @(negedge eph1);
      check({tag, ".busy_after_done"}, busy,             1'b0);
      check({tag, ".cmd_ready_back"},  bus_if.cmd_ready, 1'b1);
    end else begin
      bus_if.in_valid = 1'b0;
    end
  endtask

  initial begin
    int need;
    reset               = 1'b1;
    core_done           = 1'b0;
    bus_if.cmd_valid    = 1'b0;
    bus_if.cmd_opmode   = 1'b0;
    bus_if.cmd_keep_key = 1'b0;
    bus_if.in_valid     = 1'b0;
    bus_if.in_data      = '0;
    model_reset();
    s1_words = '{32'h34353637, 32'h30313233, 32'h3c3d3e3f, 32'h38393a3b,
                 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                 32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f,
                 32'h40414243, 32'h44454647, 32'h48494a4b, 32'h4c4d4e4f,
                 32'h4a4b4c4d, 32'h4d4e4f50};

    repeat (2) @(posedge eph1);
    do_reset("reset0");

    // Done in IDLE must not disturb anything.
    @(posedge eph1); #1;
    core_done = 1'b1;
    @(posedge eph1); #1;
    core_done = 1'b0;
    @(negedge eph1);
    check("idle_done.busy",      busy,             1'b0);
    check("idle_done.cmd_ready", bus_if.cmd_ready, 1'b1);

    // Encrypt, full rate.
    stim_q = s1_words;
    model_frame(1'b0, 1'b0, need);
    run_frame("enc", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_outputs("enc");
    check("enc.key_vec", key, S1_KEY);

    // Decrypt, random operands, known tag, done pulsed during FIRE.
    stim_q.delete();
    for (int i = 0; i < 18; i++) stim_q.push_back($urandom);
    stim_q.push_back(32'h89abcdef); stim_q.push_back(32'h01234567);
    stim_q.push_back(32'h89abcdef); stim_q.push_back(32'h01234567);
    model_frame(1'b1, 1'b0, need);
    run_frame("dec", 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    check_outputs("dec");
    check("dec.tag_vec", verification_data, TAG_V);
    check("dec.opmode1", opmode, 1'b1);

    // Encrypt again with random gaps and in_valid held through BUSY.
    stim_q = s1_words;
    model_frame(1'b0, 1'b0, need);
    run_frame("stall", 1'b0, 1'b0, 35, 1'b1, 1'b0, 1'b1);
    check_outputs("stall");
    check("stall.key_vec", key, S1_KEY);

    // Keep-key frame of 14 words.
    stim_q.delete();
    for (int i = 0; i < 14; i++) stim_q.push_back($urandom);
    model_frame(1'b0, 1'b1, need);
    run_frame("keep", 1'b0, 1'b1, 0, 1'b0, 1'b0, need == 14);
    check_outputs("keep");
    if (KK_HONOURED) check("keep.key_vec", key, S1_KEY);

    // Reset in the middle of LOAD_AD, then a clean frame.
    do_reset("reset1");
    stim_q = s1_words[0:9];
    model_frame(1'b0, 1'b0, need);
    run_frame("part", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_outputs("part");
    do_reset("reset_ad");
    stim_q = s1_words;
    model_frame(1'b0, 1'b0, need);
    run_frame("clean", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_outputs("clean");
    check("clean.key_vec", key, S1_KEY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xoodyak_loader.md
# xoodyak_loader

Word-serial front end for `xoodyak_build`.
- Accepts a command and then a stream of 32-bit words over valid/ready handshakes.
- Assembles them into the wide key, nonce, associated-data, text and verification-tag registers.
- Pulses `start` for exactly one cycle, holds all operands stable until the core reports completion, then accepts the next frame.
- Sits directly upstream of `xoodyak_build`; its outputs connect one-to-one to the core's operand and `start`/`opmode` inputs.

## Interface
Parameters:
- WORD_W, 32, stream word width; fixed; other values unsupported.

Ports:
- eph1  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_opmode  in  1  0 = encrypt, 1 = decrypt.
- cmd_keep_key  in  1  skip key load and reuse the held key (see Configuration).
- in_valid  in  1  stream word present.
- in_ready  out  1  high in any LOAD_* state.
- in_data  in  32  stream word.
- core_done  in  1  completion pulse from the core (`sqzdone`).
- key  out  128  assembled key.
- nonce  out  128  assembled nonce.
- assodata  out  128  assembled associated data.
- textin  out  192  assembled plaintext or ciphertext.
- verification_data  out  128  assembled tag; decrypt only.
- opmode  out  1  latched cmd_opmode.
- start  out  1  single-cycle start to the core.
- busy  out  1  high from command accept until core_done.

## Operation
- FSM states and transitions:
  - IDLE → LOAD_KEY on cmd_valid; goes to LOAD_NONCE instead when keep_key is effective.
  - LOAD_KEY(4 words) → LOAD_NONCE(4) → LOAD_AD(4) → LOAD_TEXT(6).
  - From LOAD_TEXT: → LOAD_TAG(4) if opmode=1, else → FIRE.
  - LOAD_TAG → FIRE → BUSY → IDLE on core_done.
- Command accept (cmd_valid & cmd_ready) latches opmode and keep_key.
- 3-bit word counter:
  - Increments on each in_valid & in_ready.
  - Clears on each state change.
  - The last word of a field advances the state on the same edge.
- Word k of a field is written to bits [32k+31:32k]; word 0 is least significant.
- Each field register is written only in its own LOAD state; all other bits hold.
- LOAD_TAG is skipped for encrypt; verification_data then holds its previous value.
- FIRE lasts one cycle:
  - start=1.
  - in_ready=0, cmd_ready=0.
- BUSY: all operand outputs are frozen; in_ready=0.
- core_done outside BUSY is ignored.
- A core_done arriving in the FIRE cycle is ignored; the core cannot finish in 0 cycles.
- in_valid while in_ready=0: no effect, no word consumed.
- Reset asserted at any point, including mid-frame: state goes to IDLE, counter=0, all field registers=0, opmode=0.

## Timing
- Reset values:
  - key, nonce, assodata, textin, verification_data = 0.
  - opmode=0, start=0, busy=0, in_ready=0.
  - cmd_ready=1 once reset deasserts.
- in_ready, cmd_ready and start are combinational decodes of registered state; no input-to-output combinational path.
- Full-rate stream with no bubbles:
  - Encrypt: 18 words, so start rises 1+18 cycles after the command-accept edge.
  - Decrypt: 22 words, 1+22 cycles.
  - Keep-key encrypt: 14 words, 1+14 cycles.
- Stalls (in_valid=0) add cycles 1:1.
- busy rises the cycle after command accept and falls the cycle after core_done is sampled in BUSY.
- cmd_ready returns high the same cycle busy falls. Back-to-back frames have a minimum gap of 0 idle cycles beyond that.

## Configuration
- `XOODYAK_LOADER_KEYHOLD_EN` defined:
  - cmd_keep_key is honoured.
  - keep_key=1 skips LOAD_KEY and leaves `key` unchanged from the previous frame.
  - keep_key=1 while key is still at its reset value is still honoured (key stays 0).
- Undefined:
  - The port exists but is ignored.
  - Every frame loads the key.

## Structure
- Shared package `xoodyak_pkg`:
  - State enum `loader_state_t`.
  - Field word counts: KEY_WORDS=4, NONCE_WORDS=4, AD_WORDS=4, TEXT_WORDS=6, TAG_WORDS=4.
  - Field widths.
- One sub-module: `xoodyak_field_reg` — parameterised word-addressed wide register with write enable and word index. Instantiated five times.
- Registers are built from the existing library register cells with async reset.

## Test plan
- Encrypt frame:
  - Stimulus: key words 34353637, 30313233, 3c3d3e3f, 38393a3b, then the nonce/AD/text words matching the system vectors.
  - Required: key == 38393a3b3c3d3e3f3031323334353637, textin == 4d4e…4a4b4c, start pulses exactly once, at cycle 19.
- Decrypt frame:
  - Stimulus: 22 words with tag 0x0123…ef.
  - Required: opmode=1, verification_data matches the tag, start at cycle 23.
- Stall/backpressure:
  - Stimulus: random in_valid gaps; in_valid held high during BUSY.
  - Required: identical outputs to the first scenario; no word consumed in BUSY.
- Keep-key (macro defined):
  - Stimulus: second frame with keep_key=1 and 14 words.
  - Required: key unchanged, start at cycle 15.
  - Macro undefined: the same 14-word frame shifts every field by one field.
- Reset mid-LOAD_AD:
  - Required: all outputs 0, cmd_ready=1 after deassert.
  - A subsequent clean frame produces the same result as the first scenario.
- core_done handling:
  - core_done pulsed in IDLE and in FIRE: ignored.
  - core_done pulsed in BUSY: busy falls next cycle.
